// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU front end: op-codes, FSM states, lane index.
package alu_pkg;

    localparam int unsigned OpMul = 8;
    localparam int unsigned OpDiv = 9;
    localparam int unsigned OpSll = 10;
    localparam int unsigned OpSrl = 11;

    typedef logic lane_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSettle,
        StWait,
        StResp
    } state_e;

    // DIV exists on the ALU but is not offered through this arbiter.
    function automatic logic is_legal_op(input logic [31:0] op);
        return (op == OpMul) || (op == OpSll) || (op == OpSrl);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter: the lane not granted last wins a tie.
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output lane_t      gnt_lane
);

    lane_t last_q, last_d;

    always_comb begin
        gnt_lane = 1'b0;
        case (req)
            2'b01:   gnt_lane = 1'b0;
            2'b10:   gnt_lane = 1'b1;
            2'b11:   gnt_lane = ~last_q;
            default: gnt_lane = 1'b0;
        endcase

        gnt = '0;
        if (req != 2'b00) begin
            gnt = gnt_lane ? 2'b10 : 2'b01;
        end

        last_d = last_q;
        if (advance && (req != 2'b00)) begin
            last_d = gnt_lane;
        end
    end

    // Reset to lane 1 so lane 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mcalu_arbiter.sv
// Two-lane issue arbiter in front of a multi-cycle ALU: grants one request at a time,
// sequences the ALU start/settle/wait handshake and returns a tagged response.
module mcalu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH  = 64,
    parameter int unsigned OPCODE_WIDTH   = 4,
    parameter int unsigned TAG_WIDTH      = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0][OPCODE_WIDTH-1:0]  req_op,
    input  logic [1:0][OPERAND_WIDTH-1:0] req_a,
    input  logic [1:0][OPERAND_WIDTH-1:0] req_b,
    input  logic [1:0][TAG_WIDTH-1:0]     req_tag,
    output logic [1:0]                    resp_valid,
    input  logic [1:0]                    resp_ready,
    output logic [OPERAND_WIDTH-1:0]      resp_data,
    output logic [TAG_WIDTH-1:0]          resp_tag,
    output logic                          resp_err,
    output logic                          alu_enable_seq,
    output logic [OPCODE_WIDTH-1:0]       alu_op_code,
    output logic [OPERAND_WIDTH-1:0]      alu_operand_1,
    output logic [OPERAND_WIDTH-1:0]      alu_operand_2,
    input  logic                          alu_idle,
    input  logic [OPERAND_WIDTH-1:0]      alu_result,
    output logic                          busy
);

    // One counter serves both the 2-cycle settle and the WAIT timeout.
    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    lane_t                    lane_q, lane_d;
    logic [OPCODE_WIDTH-1:0]  op_q, op_d;
    logic [OPERAND_WIDTH-1:0] a_q, a_d;
    logic [OPERAND_WIDTH-1:0] b_q, b_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;
    logic [OPERAND_WIDTH-1:0] data_q, data_d;
    logic                     err_q, err_d;

    logic [1:0] gnt;
    lane_t      gnt_lane;
    logic       in_idle;
    logic       legal_op;

    assign in_idle  = (state_q == StIdle);
    assign legal_op = is_legal_op(32'(req_op[gnt_lane]));

    rr_arbiter2 u_rr_arbiter2 (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .advance  (in_idle),
        .gnt      (gnt),
        .gnt_lane (gnt_lane)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        data_d  = data_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (gnt != 2'b00) begin
                    lane_d = gnt_lane;
                    op_d   = req_op[gnt_lane];
                    a_d    = req_a[gnt_lane];
                    b_d    = req_b[gnt_lane];
                    tag_d  = req_tag[gnt_lane];
                    cnt_d  = '0;
                    if (legal_op) begin
                        state_d = StStart;
                    end else begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                // alu_idle is stale here until the ALU's edge detector has seen the start.
                if (cnt_q == CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWait: begin
                if (alu_idle) begin
                    data_d  = alu_result;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (resp_ready[lane_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lane_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Operands stay on the ALU bus for the whole transaction; shifts re-read them each cycle.
    assign req_ready      = (in_idle && !rst) ? gnt : 2'b00;
    assign resp_valid     = (state_q == StResp) ? (lane_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data      = data_q;
    assign resp_tag       = tag_q;
    assign resp_err       = err_q;
    assign alu_enable_seq = (state_q == StStart);
    assign alu_op_code    = op_q;
    assign alu_operand_1  = a_q;
    assign alu_operand_2  = b_q;
    assign busy           = !in_idle;

endmodule

// File: tb/tb_mcalu_arbiter.sv
// Directed bench for mcalu_arbiter with a transaction-level reference model and a toy ALU.
module tb_mcalu_arbiter;

    localparam int unsigned OW = 64;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = 5;
    localparam int unsigned TO = 16;
    localparam int          ALU_LAT = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           req_valid = 2'b00;
    logic [1:0]           req_ready;
    logic [1:0][CW-1:0]   req_op = '0;
    logic [1:0][OW-1:0]   req_a = '0;
    logic [1:0][OW-1:0]   req_b = '0;
    logic [1:0][TW-1:0]   req_tag = '0;
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready = 2'b11;
    logic [OW-1:0]        resp_data;
    logic [TW-1:0]        resp_tag;
    logic                 resp_err;
    logic                 alu_enable_seq;
    logic [CW-1:0]        alu_op_code;
    logic [OW-1:0]        alu_operand_1;
    logic [OW-1:0]        alu_operand_2;
    logic                 alu_idle;
    logic [OW-1:0]        alu_result;
    logic                 busy;
    logic                 alu_hang = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int en_pulses = 0;
    int alu_cnt = 0;

    mcalu_arbiter #(
        .OPERAND_WIDTH  (OW),
        .OPCODE_WIDTH   (CW),
        .TAG_WIDTH      (TW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_tag        (req_tag),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_tag       (resp_tag),
        .resp_err       (resp_err),
        .alu_enable_seq (alu_enable_seq),
        .alu_op_code    (alu_op_code),
        .alu_operand_1  (alu_operand_1),
        .alu_operand_2  (alu_operand_2),
        .alu_idle       (alu_idle),
        .alu_result     (alu_result),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] alu_ref(input logic [CW-1:0] op, input logic [OW-1:0] a,
                                              input logic [OW-1:0] b);
        case (op)
            4'd8:    return a * b;
            4'd10:   return a << b[5:0];
            4'd11:   return a >> b[5:0];
            default: return '0;
        endcase
    endfunction

    // Toy ALU: goes busy for ALU_LAT cycles after a start pulse, or forever when hung.
    always @(posedge clk) begin
        if (alu_enable_seq) alu_cnt <= ALU_LAT;
        else if (alu_cnt > 0) alu_cnt <= alu_cnt - 1;
    end
    assign alu_idle   = !alu_hang && (alu_cnt == 0);
    assign alu_result = alu_ref(alu_op_code, alu_operand_1, alu_operand_2);

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference model: one outstanding transaction, round-robin grant, expected response.
    logic          m_active = 1'b0;
    logic          m_last = 1'b1;
    logic          m_lane;
    logic          m_legal;
    logic [OW-1:0] m_data;
    logic          m_err;
    logic [TW-1:0] m_tag;
    logic [CW-1:0] m_op;
    logic [1:0]    m_rdy;
    int            m_en;

    initial forever begin
        @(negedge clk);
        if (alu_enable_seq && !rst) en_pulses++;
        if (rst) begin
            m_active = 1'b0;
            m_last   = 1'b1;
        end else if (!m_active) begin
            case (req_valid)
                2'b01:   m_rdy = 2'b01;
                2'b10:   m_rdy = 2'b10;
                2'b11:   m_rdy = m_last ? 2'b01 : 2'b10;
                default: m_rdy = 2'b00;
            endcase
            check("model grant", 256'(req_ready), 256'(m_rdy));
            check("model idle outputs", 256'({busy, resp_valid, alu_enable_seq}), 256'(0));
            if (m_rdy != 2'b00) begin
                m_lane   = m_rdy[1];
                m_last   = m_lane;
                m_op     = req_op[m_lane];
                m_tag    = req_tag[m_lane];
                m_legal  = m_op inside {4'd8, 4'd10, 4'd11};
                m_en     = 0;
                m_active = 1'b1;
                if (m_legal && !alu_hang) begin
                    m_data = alu_ref(m_op, req_a[m_lane], req_b[m_lane]);
                    m_err  = 1'b0;
                end else begin
                    m_data = '0;
                    m_err  = 1'b1;
                end
            end
        end else begin
            check("model txn quiet", 256'({req_ready, busy}), 256'({2'b00, 1'b1}));
            if (alu_enable_seq) m_en++;
            if (resp_valid != 2'b00) begin
                check("model resp lane", 256'(resp_valid), 256'(m_lane ? 2'b10 : 2'b01));
                check("model resp payload", 256'({resp_data, resp_err, resp_tag}),
                      256'({m_data, m_err, m_tag}));
                if (resp_ready[m_lane]) begin
                    check("model start pulses", 256'(m_en), 256'(m_legal ? 1 : 0));
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic drive_req(input int lane, input logic [CW-1:0] op, input logic [OW-1:0] a,
                             input logic [OW-1:0] b, input logic [TW-1:0] tag);
        req_op[lane]    = op;
        req_a[lane]     = a;
        req_b[lane]     = b;
        req_tag[lane]   = tag;
        req_valid[lane] = 1'b1;
    endtask

    task automatic wait_grant(input int lane, input string name);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (req_ready[lane]) got = 1'b1;
            else n++;
        end
        check(name, 256'(got), 256'(1));
        @(posedge clk);
        #1;
        req_valid[lane] = 1'b0;
    endtask

    task automatic wait_resp(input int lane, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (resp_valid[lane]) got = 1'b1;
        end
        if (!got) lat = -1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int lat;
    int en0;
    logic [1:0] seen_valid;

    initial begin
        repeat (3) next_cycle();
        @(negedge clk);
        check("reset outputs", 256'({req_ready, resp_valid, resp_data, resp_tag, resp_err,
              alu_enable_seq, alu_op_code, alu_operand_1, alu_operand_2, busy}), 256'(0));
        next_cycle();
        rst = 1'b0;

        // Lane 0 MUL 6*7
        en0 = en_pulses;
        drive_req(0, 4'd8, 64'd6, 64'd7, 5'd17);
        wait_grant(0, "mul grant");
        wait_resp(0, lat);
        check("mul latency", 256'(lat), 256'(6));
        check("mul result", 256'({resp_data, resp_err, resp_tag}), 256'({64'd42, 1'b0, 5'd17}));
        next_cycle();
        check("mul start pulses", 256'(en_pulses - en0), 256'(1));

        // Lane 1 DIV is refused without touching the ALU
        en0 = en_pulses;
        drive_req(1, 4'd9, 64'd100, 64'd3, 5'd9);
        wait_grant(1, "div grant");
        wait_resp(1, lat);
        check("div latency", 256'(lat), 256'(1));
        check("div result", 256'({resp_data, resp_err, resp_tag}), 256'({64'd0, 1'b1, 5'd9}));
        next_cycle();
        check("div start pulses", 256'(en_pulses - en0), 256'(0));

        // Simultaneous requests, two rounds: lane 0 then lane 1 each time
        for (int r = 0; r < 2; r++) begin
            drive_req(0, 4'd10, 64'd1, 64'd4, 5'd1);
            drive_req(1, 4'd11, 64'd256, 64'd2, 5'd2);
            @(negedge clk);
            check("rr first grant", 256'(req_ready), 256'(2'b01));
            next_cycle();
            req_valid[0] = 1'b0;
            wait_resp(0, lat);
            check("rr sll result", 256'({resp_data, resp_err}), 256'({64'd16, 1'b0}));
            next_cycle();
            @(negedge clk);
            check("rr second grant", 256'(req_ready), 256'(2'b10));
            next_cycle();
            req_valid[1] = 1'b0;
            wait_resp(1, lat);
            check("rr srl latency", 256'(lat), 256'(6));
            check("rr srl result", 256'({resp_data, resp_err}), 256'({64'd64, 1'b0}));
            next_cycle();
        end

        // ALU never finishes: timeout after 16 WAIT cycles
        alu_hang = 1'b1;
        en0 = en_pulses;
        drive_req(0, 4'd8, 64'd3, 64'd3, 5'd4);
        wait_grant(0, "timeout grant");
        wait_resp(0, lat);
        check("timeout latency", 256'(lat), 256'(20));
        check("timeout result", 256'({resp_data, resp_err, resp_tag}), 256'({64'd0, 1'b1, 5'd4}));
        next_cycle();
        alu_hang = 1'b0;
        check("timeout start pulses", 256'(en_pulses - en0), 256'(1));

        // Back-pressure on lane 0 for 10 cycles while lane 1 waits
        resp_ready = 2'b10;
        drive_req(0, 4'd8, 64'd12, 64'd12, 5'd7);
        wait_grant(0, "stall grant");
        drive_req(1, 4'd10, 64'd3, 64'd2, 5'd8);
        wait_resp(0, lat);
        for (int i = 0; i < 10; i++) begin
            check("stall hold", 256'({resp_valid, req_ready, resp_data, resp_err, resp_tag}),
                  256'({2'b01, 2'b00, 64'd144, 1'b0, 5'd7}));
            next_cycle();
            if (i == 9) resp_ready = 2'b11;
            @(negedge clk);
        end
        next_cycle();
        @(negedge clk);
        check("stall pending grant", 256'(req_ready), 256'(2'b10));
        next_cycle();
        req_valid[1] = 1'b0;
        wait_resp(1, lat);
        check("stall lane1 result", 256'({resp_data, resp_err, resp_tag}),
              256'({64'd12, 1'b0, 5'd8}));
        next_cycle();

        // Reset while waiting on the ALU aborts silently
        drive_req(0, 4'd8, 64'd5, 64'd5, 5'd3);
        wait_grant(0, "abort grant");
        repeat (3) next_cycle();
        check("abort in wait", 256'({busy, resp_valid}), 256'({1'b1, 2'b00}));
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort outputs", 256'({req_ready, resp_valid, resp_data, resp_tag, resp_err,
              alu_enable_seq, alu_op_code, alu_operand_1, alu_operand_2, busy}), 256'(0));
        next_cycle();
        rst = 1'b0;
        seen_valid = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | resp_valid;
        end
        check("abort no response", 256'(seen_valid), 256'(0));
        next_cycle();
        drive_req(0, 4'd8, 64'd5, 64'd5, 5'd3);
        wait_grant(0, "post-reset grant");
        wait_resp(0, lat);
        check("post-reset latency", 256'(lat), 256'(6));
        check("post-reset result", 256'({resp_data, resp_err, resp_tag}),
              256'({64'd25, 1'b0, 5'd3}));
        next_cycle();
        repeat (2) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
